// File: rtl/pending_encoder_32x5_if.sv
// Handshake/bus bundle for pending_encoder_32x5.
// master: request producer and index consumer (drives req_i, req_valid_i, ready_i).
// slave:  the encoder (drives out_o, valid_o, pending_o, count_o).
interface pending_encoder_32x5_if;
    logic [31:0] req_i;        // request vector, bit n requests index n
    logic        req_valid_i;  // qualifies req_i for this cycle
    logic        ready_i;      // consumer accepts out_o when valid_o=1
    logic [4:0]  out_o;        // offered index (registered)
    logic        valid_o;      // out_o holds a pending index (registered)
    logic [31:0] pending_o;    // current pending register
    logic [5:0]  count_o;      // popcount of pending_o, 0..32

    modport master (
        output req_i, req_valid_i, ready_i,
        input  out_o, valid_o, pending_o, count_o
    );

    modport slave (
        input  req_i, req_valid_i, ready_i,
        output out_o, valid_o, pending_o, count_o
    );
endinterface

// File: rtl/pending_encoder_32x5.sv
// Purpose: collects multi-hot 32-bit requests, serialises them as 5-bit indices over valid/ready.
// Latency: request captured on edge t is offered (valid_o=1) right after edge t when pending was empty.
// Backpressure: offer held stable while ready_i=0; one index per cycle with ready_i held high.
//
// Ports: clk_i (rising edge), reset_i (async, active-high), bus (slave modport):
//   req_i/req_valid_i in, ready_i in, out_o/valid_o out (registered),
//   pending_o out (registered), count_o out (combinational popcount of pending_o).
// Build option: ENCODER_RR_EN selects round-robin search starting after the last
//   accepted index; when undefined, the lowest pending index wins.
module pending_encoder_32x5 #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    pending_encoder_32x5_if.slave bus
);

    // valid_o is the state register itself: OFFER <=> valid_o=1
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [WIDTH-1:0]   clear_mask, set_mask;
    logic [IDX_W-1:0]   out_q, out_d;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               accept;
    logic [IDX_W:0]     count;

    assign accept = (state_q == OFFER) && bus.ready_i;

    always_comb begin
        clear_mask = '0;
        if (accept) begin
            clear_mask[out_q] = 1'b1;
        end
    end

    assign set_mask = bus.req_valid_i ? bus.req_i : '0;

    // Set is ORed after the clear, so a re-request of the accepted bit keeps it pending
    assign pending_d = (pending_q & ~clear_mask) | set_mask;

`ifdef ENCODER_RR_EN
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] cand;

    assign start_idx = last_q + 1'b1;

    // Scan offsets from high to low so the smallest offset from start_idx wins;
    // the 5-bit add wraps past 31 back to 0.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            cand = start_idx + IDX_W'(i);
            if (pending_d[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_q <= '0;
        end else if (accept) begin
            last_q <= out_q;
        end
    end
`else
    // Fixed priority: scanning downwards leaves the lowest set index in pick_idx
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending_d[i]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Next-state / next-offer. pick_idx is 0 when nothing is pending, which
    // keeps out_o at 0 whenever valid_o drops.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                state_d = pick_vld ? OFFER : IDLE;
                out_d   = pick_idx;
            end
            OFFER: begin
                // Without an accept the offer is held; a newer lower-index
                // request waits its turn.
                if (accept) begin
                    state_d = pick_vld ? OFFER : IDLE;
                    out_d   = pick_idx;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            out_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + {{IDX_W{1'b0}}, pending_q[i]};
        end
    end

    assign bus.out_o     = out_q;
    assign bus.valid_o   = (state_q == OFFER);
    assign bus.pending_o = pending_q;
    assign bus.count_o   = count;

endmodule

// File: tb/tb_pending_encoder_32x5.sv
// Directed bench for pending_encoder_32x5: expected indices are queued when
// requests are driven and popped whenever the DUT completes a handshake.
module tb_pending_encoder_32x5;

    logic clk;
    logic rst;

    pending_encoder_32x5_if bus ();

    pending_encoder_32x5 dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scores a handshake due at the coming edge, then advances one cycle
    // and settles 1 time unit past the edge.
    task automatic tick();
        logic [4:0] e;
        if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL accept_unexpected observed=0x%0h expected=none", bus.out_o);
            end else begin
                e = exp_q.pop_front();
                check("accept_idx", 32'(bus.out_o), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        bus.req_i       = '0;
        bus.req_valid_i = 1'b0;
        bus.ready_i     = 1'b0;

        // Reset state
        #3;
        check("rst_valid",   32'(bus.valid_o), 32'd0);
        check("rst_out",     32'(bus.out_o),   32'd0);
        check("rst_pending", bus.pending_o,    32'd0);
        check("rst_count",   32'(bus.count_o), 32'd0);
        #9;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single request: offered next cycle, cleared on accept
        bus.req_i = 32'h0000_0001; bus.req_valid_i = 1'b1;
        exp_q.push_back(5'd0);
        tick();
        bus.req_valid_i = 1'b0;
        check("t1_valid", 32'(bus.valid_o), 32'd1);
        check("t1_out",   32'(bus.out_o),   32'd0);
        check("t1_count", 32'(bus.count_o), 32'd1);
        bus.ready_i = 1'b1;
        tick();
        check("t1_valid_after", 32'(bus.valid_o), 32'd0);
        check("t1_pend_after",  bus.pending_o,    32'd0);
        bus.ready_i = 1'b0;

        // Multi-hot drain at full throughput
        bus.req_i = 32'h8000_0014; bus.req_valid_i = 1'b1; bus.ready_i = 1'b1;
        exp_q.push_back(5'd2); exp_q.push_back(5'd4); exp_q.push_back(5'd31);
        tick();
        bus.req_valid_i = 1'b0;
        check("t2_out0",   32'(bus.out_o),   32'd2);
        check("t2_count0", 32'(bus.count_o), 32'd3);
        tick();
        check("t2_out1",   32'(bus.out_o),   32'd4);
        check("t2_count1", 32'(bus.count_o), 32'd2);
        tick();
        check("t2_out2",   32'(bus.out_o),   32'd31);
        check("t2_count2", 32'(bus.count_o), 32'd1);
        tick();
        check("t2_valid_end", 32'(bus.valid_o), 32'd0);
        check("t2_count_end", 32'(bus.count_o), 32'd0);
        check("t2_out_idle",  32'(bus.out_o),   32'd0);
        bus.ready_i = 1'b0;

        // Held offer is not pre-empted by a lower-index arrival
        bus.req_i = 32'h0000_0020; bus.req_valid_i = 1'b1;
        exp_q.push_back(5'd5); exp_q.push_back(5'd0);
        tick();
        check("t3_out_first", 32'(bus.out_o), 32'd5);
        bus.req_i = 32'h0000_0001;
        tick();
        bus.req_valid_i = 1'b0;
        check("t3_hold_out", 32'(bus.out_o), 32'd5);
        check("t3_hold_pend", bus.pending_o, 32'h0000_0021);
        tick();
        check("t3_hold_out2", 32'(bus.out_o), 32'd5);
        bus.ready_i = 1'b1;
        tick();
        check("t3_next_out", 32'(bus.out_o), 32'd0);
        tick();
        check("t3_valid_end", 32'(bus.valid_o), 32'd0);
        bus.ready_i = 1'b0;

        // Same-cycle set and clear: set wins
        bus.req_i = 32'h0000_0080; bus.req_valid_i = 1'b1;
        exp_q.push_back(5'd7);
        tick();
        check("t4_out", 32'(bus.out_o), 32'd7);
        bus.ready_i = 1'b1;
        exp_q.push_back(5'd7);
        tick();
        bus.req_valid_i = 1'b0;
        check("t4_rearm_pend",  bus.pending_o,    32'h0000_0080);
        check("t4_rearm_out",   32'(bus.out_o),   32'd7);
        check("t4_rearm_valid", 32'(bus.valid_o), 32'd1);
        tick();
        check("t4_valid_end", 32'(bus.valid_o), 32'd0);
        bus.ready_i = 1'b0;

        // Full vector then async reset mid-drain
        bus.req_i = 32'hFFFF_FFFF; bus.req_valid_i = 1'b1;
        tick();
        bus.req_valid_i = 1'b0;
        check("t5_count_full", 32'(bus.count_o), 32'd32);
        check("t5_pend_full",  bus.pending_o,    32'hFFFF_FFFF);
        bus.ready_i = 1'b1;
        exp_q.push_back(5'd0); exp_q.push_back(5'd1);
        tick();
        tick();
        check("t5_out_mid", 32'(bus.out_o), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_pend",  bus.pending_o,    32'd0);
        check("t5_rst_valid", 32'(bus.valid_o), 32'd0);
        check("t5_rst_out",   32'(bus.out_o),   32'd0);
        check("t5_rst_count", 32'(bus.count_o), 32'd0);
        bus.ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Selection order after a grant of index 0
        bus.req_i = 32'h0000_0001; bus.req_valid_i = 1'b1; bus.ready_i = 1'b1;
        exp_q.push_back(5'd0);
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        check("t6_idle", 32'(bus.valid_o), 32'd0);
        bus.req_i = 32'h0000_0009; bus.req_valid_i = 1'b1;
`ifdef ENCODER_RR_EN
        exp_q.push_back(5'd3); exp_q.push_back(5'd0);
`else
        exp_q.push_back(5'd0); exp_q.push_back(5'd3);
`endif
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        tick();
        check("t6_valid_end", 32'(bus.valid_o), 32'd0);
        check("t6_pend_end",  bus.pending_o,    32'd0);
        bus.ready_i = 1'b0;

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
